// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Dual-issue bimodal branch predictor: a table of 2^INDEX_BITS 2-bit
//   saturating counters, indexed by pc[INDEX_BITS+1:2].
//
//   Build option: define BP_STATS_EN to build the branch/mispredict counters.
//   Without it, the stat ports are tied to 0.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   lk_valid1/2, lk_pc1/2        lookup requests (slot 1 / slot 2)
//   flush                        kills predictions not yet returned
//   pred_valid1/2, pred_taken1/2 registered lookup results (1-cycle latency)
//   upd_valid1/2, upd_pc1/2      resolved branches from execute
//   upd_taken1/2                 actual outcome
//   upd_pred1/2                  prediction originally issued
//   stat_branches, stat_mispred  statistics counters
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 6,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lk_valid1,
    input  logic        lk_valid2,
    input  logic [31:0] lk_pc1,
    input  logic [31:0] lk_pc2,
    input  logic        flush,
    output logic        pred_valid1,
    output logic        pred_valid2,
    output logic        pred_taken1,
    output logic        pred_taken2,
    input  logic        upd_valid1,
    input  logic        upd_valid2,
    input  logic [31:0] upd_pc1,
    input  logic [31:0] upd_pc2,
    input  logic        upd_taken1,
    input  logic        upd_taken2,
    input  logic        upd_pred1,
    input  logic        upd_pred2,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0] lk_idx1, lk_idx2, upd_idx1, upd_idx2;

    assign lk_idx1  = lk_pc1[INDEX_BITS+1:2];
    assign lk_idx2  = lk_pc2[INDEX_BITS+1:2];
    assign upd_idx1 = upd_pc1[INDEX_BITS+1:2];
    assign upd_idx2 = upd_pc2[INDEX_BITS+1:2];

    // Bits outside the index field (and upd_pred when stats are off).
    logic unused_bits;
    assign unused_bits = ^{lk_pc1[31:INDEX_BITS+2], lk_pc1[1:0],
                           lk_pc2[31:INDEX_BITS+2], lk_pc2[1:0],
                           upd_pc1[31:INDEX_BITS+2], upd_pc1[1:0],
                           upd_pc2[31:INDEX_BITS+2], upd_pc2[1:0],
                           upd_pred1, upd_pred2};

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'd1;
        else       return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // Counter table
    // ------------------------------------------------------------------
    logic [1:0] tbl_q [ENTRIES];
    logic [1:0] tbl_d [ENTRIES];

    // Slot 2 is applied on top of slot 1's result, so two updates to the
    // same index move the counter by their net effect in one edge.
    always_comb begin
        tbl_d = tbl_q;
        if (upd_valid1) tbl_d[upd_idx1] = sat_step(tbl_d[upd_idx1], upd_taken1);
        if (upd_valid2) tbl_d[upd_idx2] = sat_step(tbl_d[upd_idx2], upd_taken2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= INIT_STATE;
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // ------------------------------------------------------------------
    // Lookup: read the pre-update table (no bypass), one-cycle latency.
    // ------------------------------------------------------------------
    logic pred_valid1_q, pred_valid2_q, pred_taken1_q, pred_taken2_q;
    logic pred_valid1_d, pred_valid2_d, pred_taken1_d, pred_taken2_d;

    always_comb begin
        pred_valid1_d = lk_valid1 & ~flush;
        pred_valid2_d = lk_valid2 & ~flush;
        // Gate direction with valid so taken is never 1 on an idle cycle.
        pred_taken1_d = pred_valid1_d & tbl_q[lk_idx1][1];
        pred_taken2_d = pred_valid2_d & tbl_q[lk_idx2][1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid1_q <= 1'b0;
            pred_valid2_q <= 1'b0;
            pred_taken1_q <= 1'b0;
            pred_taken2_q <= 1'b0;
        end else begin
            pred_valid1_q <= pred_valid1_d;
            pred_valid2_q <= pred_valid2_d;
            pred_taken1_q <= pred_taken1_d;
            pred_taken2_q <= pred_taken2_d;
        end
    end

    assign pred_valid1 = pred_valid1_q;
    assign pred_valid2 = pred_valid2_q;
    assign pred_taken1 = pred_taken1_q;
    assign pred_taken2 = pred_taken2_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q,  stat_mispred_d;

    always_comb begin
        stat_branches_d = stat_branches_q + 32'(upd_valid1) + 32'(upd_valid2);
        stat_mispred_d  = stat_mispred_q
                        + 32'(upd_valid1 & (upd_taken1 ^ upd_pred1))
                        + 32'(upd_valid2 & (upd_taken2 ^ upd_pred2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (default parameters).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lk_valid1, lk_valid2;
    logic [31:0] lk_pc1, lk_pc2;
    logic        flush;
    logic        pred_valid1, pred_valid2, pred_taken1, pred_taken2;
    logic        upd_valid1, upd_valid2;
    logic [31:0] upd_pc1, upd_pc2;
    logic        upd_taken1, upd_taken2, upd_pred1, upd_pred2;
    logic [31:0] stat_branches, stat_mispred;

    int checks   = 0;
    int failures = 0;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n),
        .lk_valid1(lk_valid1), .lk_valid2(lk_valid2),
        .lk_pc1(lk_pc1), .lk_pc2(lk_pc2), .flush(flush),
        .pred_valid1(pred_valid1), .pred_valid2(pred_valid2),
        .pred_taken1(pred_taken1), .pred_taken2(pred_taken2),
        .upd_valid1(upd_valid1), .upd_valid2(upd_valid2),
        .upd_pc1(upd_pc1), .upd_pc2(upd_pc2),
        .upd_taken1(upd_taken1), .upd_taken2(upd_taken2),
        .upd_pred1(upd_pred1), .upd_pred2(upd_pred2),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        lk_valid1 = 0; lk_valid2 = 0; lk_pc1 = 0; lk_pc2 = 0; flush = 0;
        upd_valid1 = 0; upd_valid2 = 0; upd_pc1 = 0; upd_pc2 = 0;
        upd_taken1 = 0; upd_taken2 = 0; upd_pred1 = 0; upd_pred2 = 0;
    endtask

    // One rising edge, sample 1 time unit later, then idle all inputs.
    task automatic tick();
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic upd1(input logic [31:0] pc, input logic t);
        upd_valid1 = 1; upd_pc1 = pc; upd_taken1 = t; upd_pred1 = t;
        tick();
    endtask

    task automatic upd_dual(input logic [31:0] pc1, input logic t1,
                            input logic [31:0] pc2, input logic t2);
        upd_valid1 = 1; upd_pc1 = pc1; upd_taken1 = t1; upd_pred1 = t1;
        upd_valid2 = 1; upd_pc2 = pc2; upd_taken2 = t2; upd_pred2 = t2;
        tick();
    endtask

    task automatic lookup1(input logic [31:0] pc);
        lk_valid1 = 1; lk_pc1 = pc;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        lk_valid1 = 1; lk_pc1 = 32'h40;   // ignored while in reset
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pred_valid1 !== 1'b0) begin failures++; $display("FAIL reset_pv1 got=%b exp=0", pred_valid1); end
        checks++; if (pred_valid2 !== 1'b0) begin failures++; $display("FAIL reset_pv2 got=%b exp=0", pred_valid2); end
        checks++; if (pred_taken1 !== 1'b0) begin failures++; $display("FAIL reset_pt1 got=%b exp=0", pred_taken1); end
        checks++; if (pred_taken2 !== 1'b0) begin failures++; $display("FAIL reset_pt2 got=%b exp=0", pred_taken2); end
        checks++; if (stat_branches !== 32'd0) begin failures++; $display("FAIL reset_stat_br got=%0d exp=0", stat_branches); end
        checks++; if (stat_mispred !== 32'd0) begin failures++; $display("FAIL reset_stat_mp got=%0d exp=0", stat_mispred); end
        clear_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_first_lookup();
        lookup1(32'h100);
        checks++; if (pred_valid1 !== 1'b1) begin failures++; $display("FAIL first_pv1 got=%b exp=1", pred_valid1); end
        checks++; if (pred_taken1 !== 1'b0) begin failures++; $display("FAIL first_pt1 got=%b exp=0", pred_taken1); end
        checks++; if (pred_valid2 !== 1'b0) begin failures++; $display("FAIL first_pv2 got=%b exp=0", pred_valid2); end
        tick();
        checks++; if (pred_valid1 !== 1'b0) begin failures++; $display("FAIL idle_pv1 got=%b exp=0", pred_valid1); end
    endtask

    task automatic test_saturate();
        // 01 -> 10 -> 11 -> 11
        upd1(32'h40, 1); upd1(32'h40, 1); upd1(32'h40, 1);
        lookup1(32'h40);
        checks++; if (pred_taken1 !== 1'b1) begin failures++; $display("FAIL sat_3taken got=%b exp=1", pred_taken1); end
        upd1(32'h40, 1);                   // holds at 11
        upd1(32'h40, 0);                   // 10
        lookup1(32'h40);
        checks++; if (pred_taken1 !== 1'b1) begin failures++; $display("FAIL sat_hold11 got=%b exp=1", pred_taken1); end
        upd1(32'h40, 0);                   // 01
        lookup1(32'h40);
        checks++; if (pred_taken1 !== 1'b0) begin failures++; $display("FAIL sat_down01 got=%b exp=0", pred_taken1); end
        upd1(32'h40, 0); upd1(32'h40, 0);  // 00, holds at 00
        upd1(32'h40, 1);                   // 01
        upd1(32'h40, 1);                   // 10
        lookup1(32'h40);
        checks++; if (pred_taken1 !== 1'b1) begin failures++; $display("FAIL sat_hold00 got=%b exp=1", pred_taken1); end
        upd1(32'h40, 0);                   // back to 01
    endtask

    task automatic test_dual_same();
        upd_dual(32'h80, 1, 32'h80, 1);    // 01 -> 11
        lookup1(32'h80);
        checks++; if (pred_taken1 !== 1'b1) begin failures++; $display("FAIL dual_tt got=%b exp=1", pred_taken1); end
        upd1(32'h80, 0);                   // 10 (would be 01 if only one applied)
        lookup1(32'h80);
        checks++; if (pred_taken1 !== 1'b1) begin failures++; $display("FAIL dual_tt_is11 got=%b exp=1", pred_taken1); end
        upd1(32'h80, 1);                   // 11
        upd_dual(32'h80, 0, 32'h80, 0);    // 11 -> 01
        lookup1(32'h80);
        checks++; if (pred_taken1 !== 1'b0) begin failures++; $display("FAIL dual_nn got=%b exp=0", pred_taken1); end
        upd1(32'h80, 1);                   // 10 (would stay 01 if counter were 00)
        lookup1(32'h80);
        checks++; if (pred_taken1 !== 1'b1) begin failures++; $display("FAIL dual_nn_is01 got=%b exp=1", pred_taken1); end
        // 11 with (taken, not-taken) -> 10
        upd_dual(32'hC0, 1, 32'hC0, 1);
        upd_dual(32'hC0, 1, 32'hC0, 0);
        lookup1(32'hC0);
        checks++; if (pred_taken1 !== 1'b1) begin failures++; $display("FAIL dual_tn got=%b exp=1", pred_taken1); end
        upd1(32'hC0, 0);                   // 01
        lookup1(32'hC0);
        checks++; if (pred_taken1 !== 1'b0) begin failures++; $display("FAIL dual_tn_is10 got=%b exp=0", pred_taken1); end
    endtask

    task automatic test_dual_diff();
        upd_dual(32'h04, 1, 32'h08, 1);    // both 01 -> 10
        lk_valid1 = 1; lk_pc1 = 32'h04; lk_valid2 = 1; lk_pc2 = 32'h08;
        tick();
        checks++; if (pred_valid2 !== 1'b1) begin failures++; $display("FAIL diff_pv2 got=%b exp=1", pred_valid2); end
        checks++; if (pred_taken1 !== 1'b1) begin failures++; $display("FAIL diff_pt1 got=%b exp=1", pred_taken1); end
        checks++; if (pred_taken2 !== 1'b1) begin failures++; $display("FAIL diff_pt2 got=%b exp=1", pred_taken2); end
    endtask

    task automatic test_no_bypass();
        lk_valid1 = 1; lk_pc1 = 32'h10;
        upd_valid1 = 1; upd_pc1 = 32'h10; upd_taken1 = 1; upd_pred1 = 0;
        tick();
        checks++; if (pred_taken1 !== 1'b0) begin failures++; $display("FAIL bypass_old got=%b exp=0", pred_taken1); end
        lookup1(32'h10);
        checks++; if (pred_taken1 !== 1'b1) begin failures++; $display("FAIL bypass_new got=%b exp=1", pred_taken1); end
    endtask

    task automatic test_flush();
        lk_valid1 = 1; lk_pc1 = 32'h04; lk_valid2 = 1; lk_pc2 = 32'h08; flush = 1;
        upd_valid1 = 1; upd_pc1 = 32'h20; upd_taken1 = 1; upd_pred1 = 1;
        tick();
        checks++; if (pred_valid1 !== 1'b0) begin failures++; $display("FAIL flush_pv1 got=%b exp=0", pred_valid1); end
        checks++; if (pred_valid2 !== 1'b0) begin failures++; $display("FAIL flush_pv2 got=%b exp=0", pred_valid2); end
        checks++; if (pred_taken1 !== 1'b0) begin failures++; $display("FAIL flush_pt1 got=%b exp=0", pred_taken1); end
        lookup1(32'h20);                   // update under flush still landed
        checks++; if (pred_valid1 !== 1'b1) begin failures++; $display("FAIL flush_after_pv1 got=%b exp=1", pred_valid1); end
        checks++; if (pred_taken1 !== 1'b1) begin failures++; $display("FAIL flush_upd got=%b exp=1", pred_taken1); end
    endtask

    task automatic test_async_reset();
        lk_valid1 = 1; lk_pc1 = 32'h80;    // counter is 10
        lk_valid2 = 1; lk_pc2 = 32'h04;    // counter is 10
        tick();
        checks++; if (pred_taken1 !== 1'b1) begin failures++; $display("FAIL ares_pre_pt1 got=%b exp=1", pred_taken1); end
        #2 rst_n = 0;
        #1;                                // still before the next edge
        checks++; if (pred_valid1 !== 1'b0) begin failures++; $display("FAIL ares_pv1 got=%b exp=0", pred_valid1); end
        checks++; if (pred_taken2 !== 1'b0) begin failures++; $display("FAIL ares_pt2 got=%b exp=0", pred_taken2); end
        #1 rst_n = 1;
        lookup1(32'h80);                   // table back to 01
        checks++; if (pred_taken1 !== 1'b0) begin failures++; $display("FAIL ares_tbl got=%b exp=0", pred_taken1); end
    endtask

    task automatic test_stats();
        logic [31:0] exp_br, exp_mp;
`ifdef BP_STATS_EN
        exp_br = 32'd10; exp_mp = 32'd3;
`else
        exp_br = 32'd0;  exp_mp = 32'd0;
`endif
        rst_n = 0; #1 rst_n = 1;
        clear_inputs();
        // {taken1,pred1,taken2,pred2}: mispredicts in cycles 1, 2 and 4
        for (int c = 0; c < 5; c++) begin
            logic [3:0] v;
            case (c)
                0: v = 4'b10_11;
                1: v = 4'b00_10;
                2: v = 4'b11_00;
                3: v = 4'b01_11;
                default: v = 4'b00_00;
            endcase
            upd_valid1 = 1; upd_pc1 = 32'h3C; upd_taken1 = v[3]; upd_pred1 = v[2];
            upd_valid2 = 1; upd_pc2 = 32'h3C; upd_taken2 = v[1]; upd_pred2 = v[0];
            tick();
        end
        checks++; if (stat_branches !== exp_br) begin failures++; $display("FAIL stat_branches got=%0d exp=%0d", stat_branches, exp_br); end
        checks++; if (stat_mispred !== exp_mp) begin failures++; $display("FAIL stat_mispred got=%0d exp=%0d", stat_mispred, exp_mp); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_lookup();
        test_saturate();
        test_dual_same();
        test_dual_diff();
        test_no_bypass();
        test_flush();
        test_async_reset();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
